// File: rtl/ps2rx_fifo.sv
// ps2rx_fifo: filtered PS/2 receiver with parity/stop checking and valid/ready output FIFO; optional frame timeout via PS2RX_TIMEOUT_EN
module ps2rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ps2d,
  input  logic                         ps2c,
  input  logic                         rx_en,
  output logic                         rx_idle,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [7:0]                   m_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         parity_err_tick,
  output logic                         frame_err_tick,
  output logic                         overrun_tick,
  output logic                         timeout_tick
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t                state;
  logic [FILTER_LEN-1:0] filt, filt_next;
  logic                  f_ps2c, f_next, fall_edge;
  logic [3:0]            cnt;
  logic [9:0]            sh;
  logic                  check, push, pop, full, wr, ovr, to;
  logic [7:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wp, rp;

  assign filt_next = {ps2c, filt[FILTER_LEN-1:1]};
  assign f_next    = &filt_next ? 1'b1 : ~|filt_next ? 1'b0 : f_ps2c;
  assign fall_edge = f_ps2c & ~f_next;
  assign rx_idle   = state == IDLE;
  assign check     = state == CHECK;
  assign push      = check & sh[9] & ^sh[8:0];
  assign m_valid   = fifo_count != '0;
  assign pop       = m_valid & m_ready;
  assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign wr        = push & (~full | pop);
  assign ovr       = push & full & ~pop;
  assign m_data    = mem[rp];

`ifdef PS2RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  assign to = (state == DATA) & ~fall_edge & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  // Time spent in DATA since the last clock edge; idle states hold it at zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= (fall_edge || state != DATA) ? '0 : tcnt + 1'b1;
`else
  assign to = 1'b0;
`endif

  // Deglitch ps2c: the filtered clock only moves once the whole window agrees
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      filt   <= '1;
      f_ps2c <= 1'b1;
    end else begin
      filt   <= filt_next;
      f_ps2c <= f_next;
    end

  // Frame FSM; error/overrun/timeout pulses are registered from the same decisions
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sh              <= '0;
      parity_err_tick <= 1'b0;
      frame_err_tick  <= 1'b0;
      overrun_tick    <= 1'b0;
      timeout_tick    <= 1'b0;
    end else begin
      frame_err_tick  <= check & ~sh[9];
      parity_err_tick <= check & sh[9] & ~^sh[8:0];
      overrun_tick    <= ovr;
      timeout_tick    <= to;
      case (state)
        IDLE:
          if (fall_edge & rx_en & ~ps2d) begin
            state <= DATA;
            cnt   <= 4'd9;
          end
        DATA:
          if (to) begin
            state <= IDLE;
            sh    <= '0;
          end else if (fall_edge) begin
            sh <= {ps2d, sh[9:1]};
            if (cnt == 4'd0) state <= CHECK;
            else cnt <= cnt - 4'd1;
          end
        default: state <= IDLE;
      endcase
    end

  // Show-ahead FIFO; a pop frees a slot for a push in the same cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= sh[7:0];
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
endmodule

// File: tb/tb_ps2rx_fifo.sv
// tb_ps2rx_fifo: directed checks of framing, errors, filtering, FIFO order/overrun, timeout and reset
module tb_ps2rx_fifo;
  logic       clk = 1'b0, reset_n, ps2d, ps2c, rx_en, m_ready;
  logic       rx_idle, m_valid, parity_err_tick, frame_err_tick, overrun_tick, timeout_tick;
  logic [7:0] m_data;
  logic [2:0] fifo_count;
  int         n_chk = 0, n_fail = 0;
  int         pe = 0, fe = 0, ov = 0, tt = 0, multi = 0;
  logic       v8, v9, v10, idle_all;
  logic [2:0] c9;

  ps2rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset_n(reset_n), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .rx_idle(rx_idle), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_count(fifo_count), .parity_err_tick(parity_err_tick),
    .frame_err_tick(frame_err_tick), .overrun_tick(overrun_tick),
    .timeout_tick(timeout_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset_n) begin
      pe    <= pe + int'(parity_err_tick);
      fe    <= fe + int'(frame_err_tick);
      ov    <= ov + int'(overrun_tick);
      tt    <= tt + int'(timeout_tick);
      multi <= multi + int'((32'(parity_err_tick) + 32'(frame_err_tick) + 32'(overrun_tick) + 32'(timeout_tick)) > 1);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s, input int nb);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      ps2d = f[i];
      ps2c = 1'b1;
      repeat (12) step();
      ps2c = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (k == 8) v8 = m_valid;
        if (k == 9) begin v9 = m_valid; c9 = fifo_count; end
        if (k == 10) v10 = m_valid;
      end
    end
    ps2c = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    reset_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; m_ready = 1'b0;
    repeat (3) step();
    chk("rst_idle", rx_idle, 1);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ticks", {parity_err_tick, frame_err_tick, overrun_tick, timeout_tick}, 0);
    reset_n = 1'b1;
    step();

    send(8'h1C, 1'b0, 1'b1, 11);
    chk("lat_before", v8, 0);
    chk("lat_valid", v9, 1);
    chk("lat_count", c9, 1);
    chk("good_data", m_data, 8'h1C);
    chk("good_count", fifo_count, 1);
    chk("good_ticks", pe + fe + ov + tt, 0);
    repeat (5) step();
    chk("hold_data", m_data, 8'h1C);
    chk("hold_valid", m_valid, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop_valid", m_valid, 0);

    send(8'h1C, 1'b1, 1'b1, 11);
    chk("parity_tick", pe, 1);
    chk("parity_count", fifo_count, 0);
    send(8'hAA, 1'b1, 1'b0, 11);
    chk("frame_tick", fe, 1);
    chk("frame_no_parity", pe, 1);
    chk("frame_count", fifo_count, 0);

    m_ready = 1'b1;
    send(8'h33, 1'b1, 1'b1, 11);
    m_ready = 1'b0;
    chk("pp_valid", v9, 1);
    chk("pp_count", c9, 1);
    chk("pp_popped", v10, 0);

    for (int b = 1; b <= 5; b++) send(8'(b), ~^8'(b), 1'b1, 11);
    chk("full_count", fifo_count, 4);
    chk("overrun_tick", ov, 1);
    chk("full_head", m_data, 8'h01);
    for (int b = 1; b <= 4; b++) begin
      chk("pop_order", m_data, b);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
    end
    chk("drained", m_valid, 0);

    ps2d = 1'b0; ps2c = 1'b0; idle_all = 1'b1;
    repeat (7) begin step(); idle_all &= rx_idle; end
    ps2c = 1'b1;
    repeat (12) begin step(); idle_all &= rx_idle; end
    chk("glitch_idle", idle_all, 1);
    ps2d = 1'b1; ps2c = 1'b0;
    repeat (12) begin step(); idle_all &= rx_idle; end
    ps2c = 1'b1;
    repeat (12) begin step(); idle_all &= rx_idle; end
    chk("bad_start_idle", idle_all, 1);
    rx_en = 1'b0;
    send(8'h1C, 1'b0, 1'b1, 11);
    rx_en = 1'b1;
    chk("rx_en_count", fifo_count, 0);
    chk("rx_en_idle", rx_idle, 1);
    chk("rx_en_ticks", pe + fe, 2);

`ifdef PS2RX_TIMEOUT_EN
    send(8'h5A, 1'b1, 1'b1, 3);
    ps2d = 1'b0; ps2c = 1'b1;
    repeat (12) step();
    ps2c = 1'b0;
    for (int k = 1; k <= 1008; k++) begin
      step();
      if (k == 1007) begin
        chk("to_early_tick", timeout_tick, 0);
        chk("to_early_busy", rx_idle, 0);
      end
      if (k == 1008) begin
        chk("to_tick", timeout_tick, 1);
        chk("to_idle", rx_idle, 1);
      end
    end
    ps2c = 1'b1;
    repeat (12) step();
    chk("to_count", tt, 1);
    chk("to_fifo", fifo_count, 0);
`endif
    send(8'h5A, 1'b1, 1'b1, 11);
    chk("5a_data", m_data, 8'h5A);
    chk("5a_count", fifo_count, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;

    send(8'h11, 1'b1, 1'b1, 11);
    send(8'h22, 1'b1, 1'b1, 11);
    chk("pre_rst_count", fifo_count, 2);
    send(8'h00, 1'b1, 1'b1, 5);
    chk("mid_frame_busy", rx_idle, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_idle", rx_idle, 1);
    step();
    reset_n = 1'b1;
    step();
    send(8'hF0, 1'b1, 1'b1, 11);
    chk("f0_data", m_data, 8'hF0);
    chk("f0_count", fifo_count, 1);
    chk("f0_valid", m_valid, 1);

`ifdef PS2RX_TIMEOUT_EN
    chk("to_total", tt, 1);
`else
    chk("to_total", tt, 0);
`endif
    chk("one_tick", multi, 0);
    chk("ovr_total", ov, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
